// File: rtl/dwt_pkg.sv
// Shared types and select codes for the lifting-DWT line controller.
package dwt_pkg;

    typedef enum logic [3:0] {
        IDLE, LOAD_E, LOAD_O, P1, P2, P3, P4, SCALE, EMIT
    } state_t;

    localparam logic [1:0] SEL_IDLE  = 2'b00;
    localparam logic [1:0] SEL_RUN   = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_RIGHT = 2'b11;

    localparam int LEVELS_MAX = 3;

    // Boundary pairs use the symmetric-extension operands on the missing side.
    function automatic logic [1:0] edge_sel(input logic first, input logic last);
        if (first)     return SEL_LEFT;
        else if (last) return SEL_RIGHT;
        else           return SEL_RUN;
    endfunction

endpackage

// File: rtl/dwt_if.sv
// Sample-in / coefficient-out handshake bundle between the controller and its environment.
interface dwt_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport master (output in_valid, out_ready, input in_ready, out_valid, out_last);
    modport slave  (input in_valid, out_ready, output in_ready, out_valid, out_last);
endinterface

// File: rtl/dwt_phase_decode.sv
// Maps the controller state and pair position onto datapath selects and enables.
module dwt_phase_decode
    import dwt_pkg::*;
(
    input  state_t      state_i,
    input  logic        first_i,
    input  logic        last_i,
    input  logic        odd_i,
    output logic [1:0]  s1_o,
    output logic [1:0]  s2_o,
    output logic [1:0]  s3_o,
    output logic [1:0]  s4_o,
    output logic [1:0]  s5_o,
    output logic [1:0]  s6_o,
    output logic        s7_o,
    output logic [3:0]  en_r_o,
    output logic [15:0] en_d_o
);

    logic [1:0] sel;
    assign sel = edge_sel(first_i, last_i);

    always_comb begin
        s1_o   = SEL_IDLE;
        s2_o   = SEL_IDLE;
        s3_o   = SEL_IDLE;
        s4_o   = SEL_IDLE;
        s5_o   = SEL_IDLE;
        s6_o   = SEL_IDLE;
        s7_o   = 1'b0;
        en_r_o = 4'h0;
        en_d_o = 16'h0000;
        case (state_i)
            P1: begin s1_o = sel; en_r_o[0] = 1'b1; en_d_o[3:0]   = 4'hF; end
            P2: begin s2_o = sel; en_r_o[1] = 1'b1; en_d_o[7:4]   = 4'hF; end
            P3: begin s3_o = sel; en_r_o[2] = 1'b1; en_d_o[11:8]  = 4'hF; end
            P4: begin s4_o = sel; en_r_o[3] = 1'b1; en_d_o[15:12] = 4'hF; end
            // Even pairs scale by K, odd pairs by 1/K.
            SCALE: begin
                s5_o = SEL_RUN;
                s6_o = SEL_RUN;
                s7_o = odd_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dwt_controller.sv
// Multi-level lifting DWT controller: sequences load, four lifting phases, scale and emit per pair.
module dwt_controller
    import dwt_pkg::*;
#(
    parameter int LEVELS = 3,
    parameter int LEN_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    dwt_if.slave             hs,
    output logic [1:0]       S1,
    output logic [1:0]       S2,
    output logic [1:0]       S3,
    output logic [1:0]       S4,
    output logic [1:0]       S5,
    output logic [1:0]       S6,
    output logic             S7,
    output logic [3:0]       en_r,
    output logic [15:0]      en_d,
    output logic [1:0]       level,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int LV = (LEVELS < 1) ? 1 : ((LEVELS > LEVELS_MAX) ? LEVELS_MAX : LEVELS);
    localparam logic [1:0] LVL_TOP = 2'(LV);

    state_t           state_q;
    logic [1:0]       level_q;
    logic [LEN_W-1:0] pairs_q;
    logic [LEN_W-1:0] pairs_lvl_q;
    logic             first_q;
    logic             odd_q;
    logic             done_q;
    logic             err_q;

    logic [LEN_W-1:0] start_pairs_d;
    logic [LEN_W-1:0] next_lvl_pairs_d;
    logic             last_w;
    logic             len_ok_w;

    assign start_pairs_d    = len >> 1;
    assign next_lvl_pairs_d = pairs_lvl_q >> 1;
    assign last_w           = (pairs_q == LEN_W'(1));
    // The deepest level must still hold at least two pairs.
    assign len_ok_w         = !len[0] && ((len >> (LV - 1)) >= LEN_W'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            level_q     <= 2'd0;
            pairs_q     <= '0;
            pairs_lvl_q <= '0;
            first_q     <= 1'b0;
            odd_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_ok_w) begin
                            state_q     <= LOAD_E;
                            level_q     <= 2'd1;
                            pairs_q     <= start_pairs_d;
                            pairs_lvl_q <= start_pairs_d;
                            first_q     <= 1'b1;
                            odd_q       <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD_E: if (hs.in_valid) state_q <= LOAD_O;
                LOAD_O: if (hs.in_valid) state_q <= P1;
                P1:     state_q <= P2;
                P2:     state_q <= P3;
                P3:     state_q <= P4;
                P4:     state_q <= SCALE;
                SCALE:  state_q <= EMIT;
                EMIT: begin
                    if (hs.out_ready) begin
                        if (!last_w) begin
                            state_q <= LOAD_E;
                            pairs_q <= pairs_q - LEN_W'(1);
                            first_q <= 1'b0;
                            odd_q   <= ~odd_q;
                        end else if (level_q < LVL_TOP) begin
                            // Next level consumes the L stream just produced.
                            state_q     <= LOAD_E;
                            level_q     <= level_q + 2'd1;
                            pairs_q     <= next_lvl_pairs_d;
                            pairs_lvl_q <= next_lvl_pairs_d;
                            first_q     <= 1'b1;
                            odd_q       <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            level_q <= 2'd0;
                            first_q <= 1'b0;
                            odd_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dwt_phase_decode u_decode (
        .state_i (state_q),
        .first_i (first_q),
        .last_i  (last_w),
        .odd_i   (odd_q),
        .s1_o    (S1),
        .s2_o    (S2),
        .s3_o    (S3),
        .s4_o    (S4),
        .s5_o    (S5),
        .s6_o    (S6),
        .s7_o    (S7),
        .en_r_o  (en_r),
        .en_d_o  (en_d)
    );

    assign hs.in_ready  = (state_q == LOAD_E) || (state_q == LOAD_O);
    assign hs.out_valid = (state_q == EMIT);
    assign hs.out_last  = (state_q == EMIT) && last_w;
    assign busy         = (state_q != IDLE);
    assign level        = level_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dwt_controller.sv
// Bench for dwt_controller: a LEVELS=1 and a LEVELS=3 instance checked against a pair-timeline model.
module tb_dwt_controller;

    localparam int LEN_W = 10;

    typedef struct packed {
        logic [1:0]  s1, s2, s3, s4, s5, s6;
        logic        s7;
        logic [3:0]  en_r;
        logic [15:0] en_d;
        logic [1:0]  level;
        logic        in_ready, out_valid, out_last, busy, done, err;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start1, start3;
    logic [LEN_W-1:0] len1, len3;

    dwt_if if1 ();
    dwt_if if3 ();

    logic [1:0]  a_s1, a_s2, a_s3, a_s4, a_s5, a_s6, a_lvl;
    logic        a_s7, a_busy, a_done, a_err;
    logic [3:0]  a_enr;
    logic [15:0] a_end;
    logic [1:0]  b_s1, b_s2, b_s3, b_s4, b_s5, b_s6, b_lvl;
    logic        b_s7, b_busy, b_done, b_err;
    logic [3:0]  b_enr;
    logic [15:0] b_end;

    dwt_controller #(.LEVELS(1), .LEN_W(LEN_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .len(len1), .hs(if1.slave),
        .S1(a_s1), .S2(a_s2), .S3(a_s3), .S4(a_s4), .S5(a_s5), .S6(a_s6), .S7(a_s7),
        .en_r(a_enr), .en_d(a_end), .level(a_lvl), .busy(a_busy), .done(a_done), .err(a_err)
    );

    dwt_controller #(.LEVELS(3), .LEN_W(LEN_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .len(len3), .hs(if3.slave),
        .S1(b_s1), .S2(b_s2), .S3(b_s3), .S4(b_s4), .S5(b_s5), .S6(b_s6), .S7(b_s7),
        .en_r(b_enr), .en_d(b_end), .level(b_lvl), .busy(b_busy), .done(b_done), .err(b_err)
    );

    obs_t o1, o3;
    always_comb begin
        o1 = {a_s1, a_s2, a_s3, a_s4, a_s5, a_s6, a_s7, a_enr, a_end, a_lvl,
              if1.in_ready, if1.out_valid, if1.out_last, a_busy, a_done, a_err};
        o3 = {b_s1, b_s2, b_s3, b_s4, b_s5, b_s6, b_s7, b_enr, b_end, b_lvl,
              if3.in_ready, if3.out_valid, if3.out_last, b_busy, b_done, b_err};
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: per instance, the line length, current level, pair index within the level,
    // samples still owed for the pair, and cycles elapsed since the odd sample was taken.
    bit m_busy [2];
    bit m_done [2];
    bit m_err  [2];
    int m_len  [2];
    int m_lvl  [2];
    int m_idx  [2];
    int m_need [2];
    int m_d    [2];

    int emit_cnt [2];
    int emit_cyc [2];
    int done_cnt [2];
    int done_cyc [2];
    int err_cnt  [2];
    int lvl_log[$];
    int last_log[$];
    int s1_log[$];

    function automatic int levels_of(input int id);
        return (id == 0) ? 1 : 3;
    endfunction

    function automatic logic [1:0] exp_sel(input bit first, input bit last);
        if (first) return 2'b10;
        if (last)  return 2'b11;
        return 2'b01;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor(input int id, input obs_t o, input logic st, input logic [LEN_W-1:0] ln,
                           input logic iv, input logic ordy);
        obs_t ex;
        int np;
        bit fst, lst;
        if (!rst_n) begin
            m_busy[id] = 1'b0;
            m_done[id] = 1'b0;
            m_err[id]  = 1'b0;
        end
        ex = '0;
        if (m_busy[id]) begin
            np  = m_len[id] >> m_lvl[id];
            fst = (m_idx[id] == 0);
            lst = (m_idx[id] == np - 1);
            ex.busy  = 1'b1;
            ex.level = 2'(m_lvl[id]);
            if (m_need[id] > 0) ex.in_ready = 1'b1;
            else begin
                case (m_d[id])
                    1: begin ex.s1 = exp_sel(fst, lst); ex.en_r = 4'b0001; ex.en_d = 16'h000F; end
                    2: begin ex.s2 = exp_sel(fst, lst); ex.en_r = 4'b0010; ex.en_d = 16'h00F0; end
                    3: begin ex.s3 = exp_sel(fst, lst); ex.en_r = 4'b0100; ex.en_d = 16'h0F00; end
                    4: begin ex.s4 = exp_sel(fst, lst); ex.en_r = 4'b1000; ex.en_d = 16'hF000; end
                    5: begin ex.s5 = 2'b01; ex.s6 = 2'b01; ex.s7 = 1'(m_idx[id] % 2); end
                    default: begin ex.out_valid = 1'b1; ex.out_last = lst; end
                endcase
            end
        end
        ex.done = m_done[id];
        ex.err  = m_err[id];
        n_vec++;
        if (o !== ex) begin
            n_err++;
            $display("FAIL outputs dut%0d cyc %0d: got %h, expected %h", id, cyc, o, ex);
        end
        if (rst_n) begin
            if (o.out_valid && ordy) begin
                emit_cnt[id]++;
                emit_cyc[id] = cyc;
                if (id == 1) begin
                    lvl_log.push_back(int'(o.level));
                    if (o.out_last) last_log.push_back(emit_cnt[1]);
                end
            end
            if (o.done) begin done_cnt[id]++; done_cyc[id] = cyc; end
            if (o.err) err_cnt[id]++;
            if (id == 0 && o.en_r[0]) s1_log.push_back(int'(o.s1));
            m_done[id] = 1'b0;
            m_err[id]  = 1'b0;
            if (!m_busy[id]) begin
                if (st) begin
                    if (!ln[0] && ((int'(ln) >> (levels_of(id) - 1)) >= 4)) begin
                        m_busy[id] = 1'b1;
                        m_len[id]  = int'(ln);
                        m_lvl[id]  = 1;
                        m_idx[id]  = 0;
                        m_need[id] = 2;
                    end else m_err[id] = 1'b1;
                end
            end else if (m_need[id] > 0) begin
                if (iv) begin
                    m_need[id]--;
                    if (m_need[id] == 0) m_d[id] = 1;
                end
            end else if (m_d[id] < 6) begin
                m_d[id]++;
            end else if (ordy) begin
                m_idx[id]++;
                m_need[id] = 2;
                if (m_idx[id] == (m_len[id] >> m_lvl[id])) begin
                    m_idx[id] = 0;
                    m_lvl[id]++;
                    if (m_lvl[id] > levels_of(id)) begin
                        m_busy[id] = 1'b0;
                        m_done[id] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor(0, o1, start1, len1, if1.in_valid, if1.out_ready);
        monitor(1, o3, start3, len3, if3.in_valid, if3.out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int id, input int base, input int limit);
        for (int i = 0; i < limit && done_cnt[id] == base; i++) tick();
        chk("done_once", done_cnt[id] - base, 1);
    endtask

    initial begin
        int be, bd, bl, bk, n1, n2, n3, be3, bd3;
        rst_n = 1'b0;
        start1 = 1'b0; start3 = 1'b0; len1 = '0; len3 = '0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.out_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", int'(b_busy), 0);
        chk("rst_level", int'(b_lvl), 0);
        chk("rst_in_ready", int'(if3.in_ready), 0);
        rst_n = 1'b1;
        tick();

        // len=8, one level
        if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        be = emit_cnt[0]; bd = done_cnt[0];
        start1 = 1'b1; len1 = 10'd8;
        tick();
        start1 = 1'b0;
        chk("l1_ready", int'(if1.in_ready), 1);
        chk("l1_level", int'(a_lvl), 1);
        wait_done(0, bd, 200);
        chk("l1_emits", emit_cnt[0] - be, 4);
        chk("l1_done_lag", done_cyc[0] - emit_cyc[0], 1);
        chk("l1_s1_count", s1_log.size(), 4);
        if (s1_log.size() == 4) begin
            chk("l1_s1_p0", s1_log[0], 2);
            chk("l1_s1_p1", s1_log[1], 1);
            chk("l1_s1_p2", s1_log[2], 1);
            chk("l1_s1_p3", s1_log[3], 3);
        end
        tick();

        // len=16, three levels
        if3.in_valid = 1'b1; if3.out_ready = 1'b1;
        be = emit_cnt[1]; bd = done_cnt[1]; bl = lvl_log.size(); bk = last_log.size();
        start3 = 1'b1; len3 = 10'd16;
        tick();
        start3 = 1'b0;
        wait_done(1, bd, 1000);
        chk("l3_emits", emit_cnt[1] - be, 14);
        n1 = 0; n2 = 0; n3 = 0;
        for (int i = bl; i < lvl_log.size(); i++) begin
            if (lvl_log[i] == 1) n1++;
            if (lvl_log[i] == 2) n2++;
            if (lvl_log[i] == 3) n3++;
        end
        chk("l3_lvl1_pairs", n1, 8);
        chk("l3_lvl2_pairs", n2, 4);
        chk("l3_lvl3_pairs", n3, 2);
        chk("l3_last_count", last_log.size() - bk, 3);
        if (last_log.size() - bk == 3) begin
            chk("l3_last_a", last_log[bk] - be, 8);
            chk("l3_last_b", last_log[bk + 1] - be, 12);
            chk("l3_last_c", last_log[bk + 2] - be, 14);
        end
        tick(); tick();
        chk("l3_done_single", done_cnt[1] - bd, 1);

        // output stall
        if3.out_ready = 1'b0;
        be = emit_cnt[1]; bd = done_cnt[1];
        start3 = 1'b1; len3 = 10'd16;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 30 && !if3.out_valid; i++) tick();
        chk("stall_reached", int'(if3.out_valid), 1);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", int'(if3.out_valid), 1);
            chk("stall_en_r", int'(b_enr), 0);
            chk("stall_en_d", int'(b_end), 0);
            if (k < 2) tick();
        end
        if3.out_ready = 1'b1;
        tick();
        chk("stall_release_valid", int'(if3.out_valid), 0);
        chk("stall_release_ready", int'(if3.in_ready), 1);
        wait_done(1, bd, 1000);
        chk("stall_emits", emit_cnt[1] - be, 14);
        tick();

        // illegal lengths
        bd = err_cnt[1];
        start3 = 1'b1; len3 = 10'd6;
        tick();
        start3 = 1'b0;
        chk("err_len6", int'(b_err), 1);
        chk("err_len6_busy", int'(b_busy), 0);
        tick();
        chk("err_len6_clear", int'(b_err), 0);
        start3 = 1'b1; len3 = 10'd10;
        tick();
        start3 = 1'b0;
        chk("err_len10", int'(b_err), 1);
        chk("err_len10_busy", int'(b_busy), 0);
        tick();
        chk("err_pulses", err_cnt[1] - bd, 2);
        start1 = 1'b1; len1 = 10'd7;
        tick();
        start1 = 1'b0;
        chk("err_odd_len", int'(a_err), 1);
        tick();

        // reset mid-line, then a fresh line
        be = emit_cnt[0];
        start1 = 1'b1; len1 = 10'd8;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 60 && !(emit_cnt[0] - be == 1 && a_enr[2]); i++) tick();
        chk("rst_hit_p3", int'(a_enr[2]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", int'(o1 == '0), 1);
        chk("rst_async_ready", int'(if1.in_ready), 0);
        tick(); tick();
        rst_n = 1'b1;
        be3 = emit_cnt[0]; bd3 = done_cnt[0];
        start1 = 1'b1; len1 = 10'd8;
        tick();
        start1 = 1'b0;
        chk("rst_restart_busy", int'(a_busy), 1);
        wait_done(0, bd3, 200);
        chk("rst_restart_emits", emit_cnt[0] - be3, 4);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dwt_controller.md
DWT_CONTROLLER -- requirements
Module: dwt_controller

Interface
REQ-001 SHALL have parameter LEVELS, default 3: number of decomposition levels, range 1-3.
REQ-002 SHALL have parameter LEN_W, default 10: width of the line-length port.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begin transform of one line.
REQ-006 SHALL have port len, input, LEN_W: level-1 sample count, sampled on accepted start.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): sample-input handshake.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): L/H output handshake.
REQ-009 SHALL have ports S1-S6, output, 2 each: per-phase datapath mux selects.
REQ-010 SHALL have port S7, output, 1: scale select; 0 = K, 1 = 1/K.
REQ-011 SHALL have port en_r, output, 4: register enables; bit k-1 drives EnRk.
REQ-012 SHALL have port en_d, output, 16: delay-unit enables; bit 4*b+s drives EnD(s+1)(a,b,c,d)[b].
REQ-013 SHALL have port level, output, 2: current decomposition level, 1-based; 0 when idle.
REQ-014 SHALL have ports out_last (output, 1): final pair of a level; busy, done, err (output, 1 each).

Function
REQ-015 FSM states SHALL be: IDLE, LOAD_E, LOAD_O, P1, P2, P3, P4, SCALE, EMIT.
REQ-016 IDLE + start SHALL go to LOAD_E with level=1 and pairs=len/2 when len is valid; otherwise stay IDLE and pulse err for 1 cycle.
REQ-017 len SHALL be valid when even and (len>>(LEVELS-1)) >= 4.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in LOAD_E/LOAD_O; each state advances only on in_valid&&in_ready.
REQ-020 LOAD_O -> P1 -> P2 -> P3 -> P4 -> SCALE -> EMIT SHALL take one cycle per state; out_valid rises 5 cycles after the odd-sample handshake.
REQ-021 In Pk (k=1..4), Sk SHALL be 2'b01 for interior pairs, 2'b10 for the first pair of a level, and 2'b11 for the last pair.
REQ-022 In Pk, en_r[k-1] SHALL be 1 and en_d[4(k-1)+:4] SHALL be 4'hF.
REQ-023 Sk SHALL be 2'b00 outside Pk.
REQ-024 In SCALE, S5=S6=2'b01 and S7 SHALL toggle per pair, starting at 0 each level.
REQ-025 All enables SHALL be 0 outside P1-P4.
REQ-026 out_valid SHALL be 1 only in EMIT and be held with all enables 0 until out_ready.
REQ-027 out_last SHALL be 1 in EMIT on the final pair of a level.
REQ-028 EMIT handshake on a non-last pair SHALL decrement the pair counter and go to LOAD_E.
REQ-029 On the last pair with level<LEVELS: level++, pairs = previous pairs/2, go to LOAD_E; level>=2 input is the looped-back L stream.
REQ-030 On the last pair with level==LEVELS: go to IDLE, pulse done for 1 cycle, level=0.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 rst_n low SHALL force, asynchronously, IDLE with all outputs 0 (S*=0, en*=0, level=0, in_ready=0, out_valid=0, done=0, err=0), including mid-line.
REQ-033 After rst_n rises, the block SHALL be ready for start on the next edge; partial-line state is discarded.

Structure
REQ-034 Package dwt_pkg SHALL hold the state enum, select codes SEL_IDLE/SEL_RUN/SEL_LEFT/SEL_RIGHT, and LEVELS_MAX=3.
REQ-035 A combinational sub-module dwt_phase_decode (state, first, last -> S1-S7, en_r, en_d) SHALL be used; counters and FSM stay in dwt_controller.

Verification
REQ-036 len=8, LEVELS=1, in_valid and out_ready held high -> 4 EMITs; S1 = 10, 01, 01, 11 across the pairs; done exactly 1 cycle after the 4th EMIT.
REQ-037 len=16, LEVELS=3 -> 8, 4, 2 EMITs with level = 1, 2, 3; out_last on EMITs 8, 12, 14; done pulses once.
REQ-038 out_ready low 3 cycles in EMIT -> out_valid held, en_r=0, en_d=0 throughout; advances on the cycle out_ready=1.
REQ-039 len=6 or len=10 with LEVELS=3 -> err pulses 1 cycle, busy stays 0.
REQ-040 rst_n low during P3 of pair 2 -> all outputs 0 immediately; a new start with len=8 completes normally.
